// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transfer sequencer.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_LEAD  = 3'd2,
        ST_XFER  = 3'd3,
        ST_TRAIL = 3'd4,
        ST_DONE  = 3'd5
    } spi_state_e;

    localparam int SPI_BITS  = 8;
    localparam int SPI_EDGES = 16;
    localparam int EDGE_W    = $clog2(SPI_EDGES + 1);

    localparam logic [EDGE_W-1:0] EDGE_ZERO  = EDGE_W'(0);
    localparam logic [EDGE_W-1:0] EDGE_FIRST = EDGE_W'(1);
    localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(SPI_EDGES);

    // States in which the slave is selected for the byte in flight.
    function automatic logic ss_active(input spi_state_e s);
        case (s)
            ST_LOAD, ST_LEAD, ST_XFER, ST_TRAIL: ss_active = 1'b1;
            default:                             ss_active = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_baud_div.sv
// Half-period counter: counts 0..div_i while enabled, flags the terminal count.
module spi_baud_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tc_o
);

    logic [DIV_W-1:0] cnt_q;

    assign tc_o = en_i && (cnt_q == div_i);

    // Counter register; the terminal count wraps to zero, so the maximum divisor never overflows.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= DIV_W'(0);
        end else if (clr_i) begin
            cnt_q <= DIV_W'(0);
        end else if (en_i) begin
            if (cnt_q == div_i) begin
                cnt_q <= DIV_W'(0);
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: SCK/SS generation, shifter load/shift/sample strobes, SPIF/WCOL.
// Define SPI_TX_BUF_EN to add a one-deep transmit buffer for back-to-back bytes.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter bit SS_AUTO = 1'b1
) (
    input  logic                clk_in,
    input  logic                rstn_in,
    input  logic                spe_in,
    input  logic                cpol_in,
    input  logic                cpha_in,
    input  logic [DIV_W-1:0]    baud_div_in,
    input  logic                ss_sw_in,
    input  logic                dr_wr_in,
    input  logic [SPI_BITS-1:0] dr_wdata_in,
    input  logic                flag_clr_in,
    input  logic [SPI_BITS-1:0] shift_data_in,
    output logic                sck_out,
    output logic                ss_n_out,
    output logic                load_out,
    output logic [SPI_BITS-1:0] tx_byte_out,
    output logic                shift_en_out,
    output logic                sample_en_out,
    output logic [SPI_BITS-1:0] rx_data_out,
    output logic                busy_out,
    output logic                spif_out,
    output logic                wcol_out
);

    spi_state_e          state_q, state_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [EDGE_W-1:0]   edge_nxt_s;
    logic                cpol_q, cpha_q;
    logic [DIV_W-1:0]    div_q;
    logic                tc_s, cnt_en_s;
    logic                toggle_s, shift_d, sample_d;
    logic                spif_set_s, wcol_set_s;
    logic                start_s, hold_ss_s, ss_low_s;
    logic [SPI_BITS-1:0] start_byte_s;

    logic                sck_q, ss_n_q, load_q, shift_q, sample_q, busy_q, spif_q, wcol_q;
    logic [SPI_BITS-1:0] tx_q, rx_q;

`ifdef SPI_TX_BUF_EN
    logic                buf_full_q, buf_full_d;
    logic [SPI_BITS-1:0] buf_q, buf_d;
`endif

    assign cnt_en_s   = (state_q == ST_LEAD) || (state_q == ST_XFER) || (state_q == ST_TRAIL);
    assign edge_nxt_s = edge_cnt_q + EDGE_FIRST;

    spi_baud_div #(.DIV_W(DIV_W)) u_baud_div (
        .clk_i  (clk_in),
        .rstn_i (rstn_in),
        .en_i   (cnt_en_s),
        .clr_i  (!cnt_en_s),
        .div_i  (div_q),
        .tc_o   (tc_s)
    );

    // Next-state, edge numbering and strobe decode.
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        toggle_s     = 1'b0;
        shift_d      = 1'b0;
        sample_d     = 1'b0;
        spif_set_s   = 1'b0;
        wcol_set_s   = 1'b0;
        start_s      = 1'b0;
        start_byte_s = dr_wdata_in;
        hold_ss_s    = 1'b0;
`ifdef SPI_TX_BUF_EN
        buf_full_d   = buf_full_q;
        buf_d        = buf_q;
`endif
        if ((state_q != ST_IDLE) && !spe_in) begin
            state_d = ST_IDLE;
`ifdef SPI_TX_BUF_EN
            buf_full_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dr_wr_in && spe_in) begin
                        state_d = ST_LOAD;
                        start_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_d    = ST_LEAD;
                    edge_cnt_d = EDGE_ZERO;
                end
                ST_LEAD, ST_XFER: begin
                    if (tc_s) begin
                        toggle_s   = 1'b1;
                        edge_cnt_d = edge_nxt_s;
                        // Odd edges lead, even edges trail; CPHA swaps which one samples.
                        if (edge_nxt_s[0]) begin
                            sample_d = !cpha_q;
                            shift_d  = cpha_q && (edge_nxt_s != EDGE_FIRST);
                        end else begin
                            sample_d = cpha_q;
                            shift_d  = !cpha_q && (edge_nxt_s != EDGE_LAST);
                        end
                        state_d = (edge_nxt_s == EDGE_LAST) ? ST_TRAIL : ST_XFER;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_TRAIL: begin
                    if (tc_s) begin
                        state_d    = ST_DONE;
                        spif_set_s = 1'b1;
                    end else begin
                        state_d = ST_TRAIL;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
`ifdef SPI_TX_BUF_EN
                    if (buf_full_q) begin
                        state_d      = ST_LOAD;
                        start_s      = 1'b1;
                        start_byte_s = buf_q;
                        buf_full_d   = 1'b0;
                    end else if (dr_wr_in) begin
                        state_d = ST_LOAD;
                        start_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase

            if (dr_wr_in && (state_q != ST_IDLE)) begin
`ifdef SPI_TX_BUF_EN
                if (buf_full_q) begin
                    wcol_set_s = 1'b1;
                end else if (state_q != ST_DONE) begin
                    buf_full_d = 1'b1;
                    buf_d      = dr_wdata_in;
                end else begin
                    wcol_set_s = 1'b0;
                end
`else
                wcol_set_s = 1'b1;
`endif
            end else begin
                wcol_set_s = 1'b0;
            end
        end
`ifdef SPI_TX_BUF_EN
        hold_ss_s = buf_full_d;
`endif
        ss_low_s = ss_active(state_d) || ((state_d == ST_DONE) && hold_ss_s);
    end

    // State, latched transfer configuration and registered outputs.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q    <= ST_IDLE;
            edge_cnt_q <= EDGE_ZERO;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= DIV_W'(0);
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            sck_q      <= 1'b0;
            ss_n_q     <= 1'b1;
            load_q     <= 1'b0;
            shift_q    <= 1'b0;
            sample_q   <= 1'b0;
            busy_q     <= 1'b0;
            spif_q     <= 1'b0;
            wcol_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            if (start_s) begin
                tx_q   <= start_byte_s;
                cpol_q <= cpol_in;
                cpha_q <= cpha_in;
                div_q  <= baud_div_in;
            end
            if ((state_d == ST_IDLE) || start_s) begin
                sck_q <= cpol_in;
            end else if (toggle_s) begin
                sck_q <= ~sck_q;
            end
            if (spif_set_s) begin
                rx_q <= shift_data_in;
            end
            ss_n_q   <= SS_AUTO ? !ss_low_s : ss_sw_in;
            load_q   <= (state_d == ST_LOAD);
            shift_q  <= shift_d;
            sample_q <= sample_d;
            busy_q   <= (state_d != ST_IDLE);
            spif_q   <= spif_set_s || (spif_q && !flag_clr_in);
            wcol_q   <= wcol_set_s || (wcol_q && !flag_clr_in);
        end
    end

`ifdef SPI_TX_BUF_EN
    // Pending-byte buffer; an abort flushes it.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            buf_full_q <= 1'b0;
            buf_q      <= 8'h00;
        end else begin
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
        end
    end
`endif

    assign sck_out       = sck_q;
    assign ss_n_out      = ss_n_q;
    assign load_out      = load_q;
    assign tx_byte_out   = tx_q;
    assign shift_en_out  = shift_q;
    assign sample_en_out = sample_q;
    assign rx_data_out   = rx_q;
    assign busy_out      = busy_q;
    assign spif_out      = spif_q;
    assign wcol_out      = wcol_q;

endmodule
